// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, S-box, Rcon and GF(2^8) helpers.
package aes_pkg;

  // Controller states of the iterative core.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // FIPS-197 S-box, entry 0x00 in the top byte and entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants for rounds 1..10.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // S-box lookup; (255 - b) * 8 is simply {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for a round number; rounds outside 1..10 give zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
      r = RCON[rnd];
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  // MixColumns on one column, top byte is row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box byte substitution.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  assign data_o = sbox(data_i);

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
module aes_encrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic [127:0] cipher_text,
  output logic         finish,
  output logic         bus_free
);

  aes_state_e   st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [31:0]  rk0, rk1, rk2, rk3;
  logic [31:0]  rk0_d, rk1_d, rk2_d, rk3_d;
  logic [3:0]   cnt, cnt_d;

  logic [7:0]   st_byte_s  [16];
  logic [7:0]   sb_byte_s  [16];
  logic [7:0]   sr_byte_s  [16];
  logic [31:0]  rot_word_s;
  logic [7:0]   sub_byte_s [4];
  logic [31:0]  key_temp_s;
  logic [31:0]  nk0_s, nk1_s, nk2_s, nk3_s;
  logic [127:0] round_key_s;
  logic [127:0] round_out_s;

  // SubBytes: one S-box per state byte, byte 0 at the top of the state word.
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    assign st_byte_s[i] = state_q[127-8*i -: 8];
    aes_sbox u_sbox (
      .data_i (st_byte_s[i]),
      .data_o (sb_byte_s[i])
    );
  end

  // SubWord(RotWord(rk3)) for the key schedule.
  assign rot_word_s = {rk3[23:0], rk3[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .data_i (rot_word_s[31-8*j -: 8]),
      .data_o (sub_byte_s[j])
    );
  end

  // Next round key from the current one; the Rcon index is the round being applied.
  assign key_temp_s  = {sub_byte_s[0], sub_byte_s[1], sub_byte_s[2], sub_byte_s[3]}
                       ^ {rcon(cnt), 24'h000000};
  assign nk0_s       = rk0 ^ key_temp_s;
  assign nk1_s       = rk1 ^ nk0_s;
  assign nk2_s       = rk2 ^ nk1_s;
  assign nk3_s       = rk3 ^ nk2_s;
  assign round_key_s = {nk0_s, nk1_s, nk2_s, nk3_s};

  // ShiftRows, MixColumns (bypassed in the last round) and AddRoundKey.
  always_comb begin
    round_out_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_byte_s[4*c+r] = sb_byte_s[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (cnt == LAST_ROUND) begin
        round_out_s[127-32*c -: 32] =
          {sr_byte_s[4*c], sr_byte_s[4*c+1], sr_byte_s[4*c+2], sr_byte_s[4*c+3]}
          ^ round_key_s[127-32*c -: 32];
      end else begin
        round_out_s[127-32*c -: 32] =
          mix_column({sr_byte_s[4*c], sr_byte_s[4*c+1], sr_byte_s[4*c+2], sr_byte_s[4*c+3]})
          ^ round_key_s[127-32*c -: 32];
      end
    end
  end

  // Next-state logic: load in INIT or on a start in DONE, one round per cycle in BUSY.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rk0_d   = rk0;
    rk1_d   = rk1;
    rk2_d   = rk2;
    rk3_d   = rk3;
    cnt_d   = cnt;
    case (st_q)
      INIT: begin
        st_d    = BUSY;
        state_d = plain_text ^ key;
        rk0_d   = key[127:96];
        rk1_d   = key[95:64];
        rk2_d   = key[63:32];
        rk3_d   = key[31:0];
        cnt_d   = 4'd1;
      end
      BUSY: begin
        state_d = round_out_s;
        rk0_d   = nk0_s;
        rk1_d   = nk1_s;
        rk2_d   = nk2_s;
        rk3_d   = nk3_s;
        if (cnt == LAST_ROUND) begin
          st_d  = DONE;
          cnt_d = LAST_ROUND;
        end else begin
          st_d  = BUSY;
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        if (start) begin
          st_d    = BUSY;
          state_d = plain_text ^ key;
          rk0_d   = key[127:96];
          rk1_d   = key[95:64];
          rk2_d   = key[63:32];
          rk3_d   = key[31:0];
          cnt_d   = 4'd1;
        end else begin
          st_d    = DONE;
        end
      end
      default: begin
        st_d  = INIT;
        cnt_d = 4'd0;
      end
    endcase
  end

  // State, round-key and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= INIT;
      state_q <= 128'h0;
      rk0     <= 32'h0;
      rk1     <= 32'h0;
      rk2     <= 32'h0;
      rk3     <= 32'h0;
      cnt     <= 4'd0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rk0     <= rk0_d;
      rk1     <= rk1_d;
      rk2     <= rk2_d;
      rk3     <= rk3_d;
      cnt     <= cnt_d;
    end
  end

  assign cipher_text = state_q;
  assign finish      = (st_q == DONE);
  assign bus_free    = (st_q == BUSY) || ((st_q == DONE) && !start);

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core using FIPS-197 vectors.
module tb_aes_encrypt_core;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] L1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] S1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RKA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic [127:0] cipher_text;
  logic         finish;
  logic         bus_free;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q [$];
  logic         fin_prev = 1'b0;

  aes_encrypt_core dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .plain_text  (plain_text),
    .key         (key),
    .cipher_text (cipher_text),
    .finish      (finish),
    .bus_free    (bus_free)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges until finish rises (bounded) and compares with the expected latency.
  task automatic wait_finish(input int exp_cycles, input string name);
    int n;
    n = 0;
    while ((finish !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'(exp_cycles));
  endtask

  // Monitor: every rising edge of finish must match the oldest queued ciphertext.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if ((finish === 1'b1) && (fin_prev == 1'b0)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got %h expected no result", cipher_text);
        end else begin
          e = exp_q.pop_front();
          if (cipher_text !== e) begin
            n_fail++;
            $display("FAIL ciphertext: got %h expected %h", cipher_text, e);
          end
        end
      end
      fin_prev = (finish === 1'b1);
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    key        = K1;
    plain_text = P1;
    tick();
    tick();
    chk("rst_finish",   128'(finish),   128'(0));
    chk("rst_cnt",      128'(dut.cnt),  128'(0));
    chk("rst_bus_free", 128'(bus_free), 128'(0));

    // Automatic run armed by reset.
    exp_q.push_back(C1);
    rst = 1'b0;
    tick();
    chk("load_state",    cipher_text,    L1);
    chk("load_cnt",      128'(dut.cnt),  128'(1));
    chk("busy_bus_free", 128'(bus_free), 128'(1));
    tick();
    chk("round1_state", cipher_text, S1);
    chk("round1_rk",    {dut.rk0, dut.rk1, dut.rk2, dut.rk3}, RK1);
    wait_finish(9, "reset_latency");
    chk("round10_rk",    {dut.rk0, dut.rk1, dut.rk2, dut.rk3}, RKA);
    chk("done_cnt",      128'(dut.cnt),  128'(10));
    chk("done_bus_free", 128'(bus_free), 128'(1));

    // Start from DONE with the FIPS-197 appendix C vector.
    key        = K2;
    plain_text = P2;
    start      = 1'b1;
    #1;
    chk("start_bus_free", 128'(bus_free), 128'(0));
    exp_q.push_back(C2);
    tick();
    start = 1'b0;
    chk("finish_drop", 128'(finish), 128'(0));
    wait_finish(10, "start_latency");

    // All-zero key and block.
    key        = 128'h0;
    plain_text = 128'h0;
    start      = 1'b1;
    exp_q.push_back(C3);
    tick();
    start = 1'b0;
    wait_finish(10, "zero_latency");

    // start pulsed while BUSY, inputs changed mid-run.
    key        = K1;
    plain_text = P1;
    start      = 1'b1;
    exp_q.push_back(C1);
    tick();
    start = 1'b0;
    tick();
    tick();
    start      = 1'b1;
    key        = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    plain_text = 128'h55aa55aa_00ff00ff_12345678_9abcdef0;
    #1;
    chk("busy_start_bus_free", 128'(bus_free), 128'(1));
    tick();
    start = 1'b0;
    wait_finish(7, "busy_start_latency");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_hold_finish", 128'(finish), 128'(1));
      chk("done_hold_text",   cipher_text,  C1);
    end

    // Reset in the middle of a run.
    key        = K2;
    plain_text = P2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    rst        = 1'b1;
    key        = K1;
    plain_text = P1;
    exp_q.push_back(C1);
    tick();
    chk("midrst_finish", 128'(finish),  128'(0));
    chk("midrst_cnt",    128'(dut.cnt), 128'(0));
    tick();
    rst = 1'b0;
    wait_finish(11, "midrst_latency");

    tick();
    tick();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
